// File: rtl/transmit_protocol_pkg.sv
// transmit_protocol_pkg: constants and state encodings shared by the serial transmitter and receiver
package transmit_protocol_pkg;
  localparam int PKT_W = 55;
  localparam int SYNC_LEN = 6;
  localparam logic [SYNC_LEN-1:0] SYNC_SEQ = 6'b011111;
  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    SYNC = 4'b0010,
    SEND = 4'b0100,
    GAP  = 4'b1000
  } state_t;
  function automatic logic sync_bit(input logic [2:0] i);
    return SYNC_SEQ[3'(SYNC_LEN-1) - i];
  endfunction
endpackage

// File: rtl/transmit_protocol_tx_piso_shreg.sv
// tx_piso_shreg: parallel-load, MSB-first shift register with load/shift enables
module tx_piso_shreg #(
  parameter int W = 55
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         msb
);
  logic [W-1:0] sh_q, sh_d;
  always_comb sh_d = load ? d : shift ? {sh_q[W-2:0], 1'b0} : sh_q;
  always_ff @(posedge clk)
    if (rst) sh_q <= '0;
    else sh_q <= sh_d;
  assign msb = sh_q[W-1];
endmodule

// File: rtl/transmit_protocol.sv
// transmit_protocol: frames packets as sync preamble + MSB-first data + idle-high gap on S_Data
// Define TX_HOLD_EN to add a one-entry hold buffer allowing gapless back-to-back frames.
module transmit_protocol
  import transmit_protocol_pkg::*;
#(
  parameter int GAP_LEN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PKT_W-1:0] packet_in,
  input  logic             send,
  output logic             tx_ready,
  output logic             S_Data,
  output logic             tx_done
);
  state_t state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic s_data_q, s_data_d;
  logic load, shift, accept, drain, msb;
  logic [PKT_W-1:0] load_data;
  logic gap_end;
  assign accept = send && tx_ready;
  assign gap_end = state_q == GAP && cnt_q == 7'(GAP_LEN-1);
`ifdef TX_HOLD_EN
  logic [PKT_W-1:0] hold_q, hold_d;
  logic hold_valid_q, hold_valid_d;
  assign tx_ready = !hold_valid_q;
  assign drain = gap_end && hold_valid_q;
  assign load_data = state_q == IDLE ? packet_in : hold_q;
  always_comb begin
    hold_d = accept && state_q != IDLE ? packet_in : hold_q;
    hold_valid_d = accept && state_q != IDLE ? 1'b1 : drain ? 1'b0 : hold_valid_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      hold_q <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
`else
  assign tx_ready = state_q == IDLE;
  assign drain = 1'b0;
  assign load_data = packet_in;
`endif
  // s_data_d is the bit for the next cycle, so S_Data stays a clean flop output
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    s_data_d = 1'b1;
    load = 1'b0;
    shift = 1'b0;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = SYNC;
        cnt_d = '0;
        load = 1'b1;
        s_data_d = sync_bit(3'd0);
      end
      SYNC: if (cnt_q == 7'(SYNC_LEN-1)) begin
        state_d = SEND;
        cnt_d = 7'(PKT_W-1);
        s_data_d = msb;
        shift = 1'b1;
      end else begin
        cnt_d = cnt_q + 7'd1;
        s_data_d = sync_bit(cnt_q[2:0] + 3'd1);
      end
      SEND: if (cnt_q == '0) begin
        state_d = GAP;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q - 7'd1;
        s_data_d = msb;
        shift = 1'b1;
      end
      GAP: if (gap_end) begin
        state_d = drain ? SYNC : IDLE;
        cnt_d = '0;
        load = drain;
        s_data_d = drain ? sync_bit(3'd0) : 1'b1;
      end else cnt_d = cnt_q + 7'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      s_data_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      s_data_q <= s_data_d;
    end
  tx_piso_shreg #(.W(PKT_W)) u_shreg (
    .clk(clk),
    .rst(rst),
    .load(load),
    .shift(shift),
    .d(load_data),
    .msb(msb)
  );
  assign S_Data = s_data_q;
  assign tx_done = state_q == GAP && cnt_q == '0;
endmodule

// File: tb/tb_transmit_protocol.sv
// tb_transmit_protocol: random stimulus checked against a frame-timeline reference model
module tb_transmit_protocol;
  import transmit_protocol_pkg::*;
  localparam int GAP_LEN = 2;
  logic clk = 1'b0, rst = 1'b1, send = 1'b0;
  logic [PKT_W-1:0] packet_in = '0;
  logic tx_ready, S_Data, tx_done;
  int vectors = 0, errors = 0;
  int e = 0, start = 0;
  bit active = 0, hold_v = 0, m_ready = 1;
  logic [PKT_W-1:0] cur = '0, hold = '0;
  always #5 clk = ~clk;
  transmit_protocol #(.GAP_LEN(GAP_LEN)) dut (
    .clk(clk),
    .rst(rst),
    .packet_in(packet_in),
    .send(send),
    .tx_ready(tx_ready),
    .S_Data(S_Data),
    .tx_done(tx_done)
  );
  function automatic logic [PKT_W-1:0] rnd();
    return PKT_W'({$urandom(), $urandom()});
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", tag, got, exp, e);
    end
  endtask
  // A frame accepted at edge a shows, after edge a+d: preamble for d<6, packet[60-d] for d<61, then idle-high
  task automatic tick(input logic s, input logic [PKT_W-1:0] p, input logic r);
    int d;
    logic exp_s;
    @(negedge clk);
    send = s;
    packet_in = p;
    rst = r;
    @(posedge clk);
    e++;
    if (r) begin
      active = 0;
      hold_v = 0;
    end else begin
      bit acc;
      acc = s && m_ready;
      if (active && e - start == 61 + GAP_LEN) begin
        active = 0;
        if (hold_v) begin
          active = 1;
          start = e;
          cur = hold;
          hold_v = 0;
        end
      end
      if (acc) begin
        if (!active) begin
          active = 1;
          start = e;
          cur = p;
        end else begin
          hold = p;
          hold_v = 1;
        end
      end
    end
`ifdef TX_HOLD_EN
    m_ready = !hold_v;
`else
    m_ready = !active;
`endif
    d = e - start;
    exp_s = !active ? 1'b1 : d < 6 ? (d != 0) : d < 61 ? cur[60-d] : 1'b1;
    #1;
    check("s_data", 64'(S_Data), 64'(exp_s));
    check("tx_ready", 64'(tx_ready), 64'(m_ready));
    check("tx_done", 64'(tx_done), 64'(active && d == 61));
  endtask
  initial begin
    repeat (3) tick(1'b0, '0, 1'b1);
    repeat (20) tick(1'b0, rnd(), 1'b0);
    tick(1'b1, 55'h5A5A5A5A5A5A5A, 1'b0);
    repeat (80) tick(1'b0, rnd(), 1'b0);
    tick(1'b1, '0, 1'b0);
    repeat (70) tick(1'b0, rnd(), 1'b0);
    tick(1'b1, {PKT_W{1'b1}}, 1'b0);
    repeat (70) tick(1'b0, rnd(), 1'b0);
    repeat (200) tick(1'b1, rnd(), 1'b0);
    repeat (140) tick(1'b0, rnd(), 1'b0);
    tick(1'b1, rnd(), 1'b0);
    repeat (29) tick(1'b0, rnd(), 1'b0);
    tick(1'b0, rnd(), 1'b1);
    repeat (10) tick(1'b0, rnd(), 1'b0);
    tick(1'b1, rnd(), 1'b0);
    tick(1'b1, rnd(), 1'b0);
    repeat (29) tick(1'b1, rnd(), 1'b0);
    tick(1'b0, rnd(), 1'b1);
    repeat (10) tick(1'b0, rnd(), 1'b0);
    repeat (1500) tick($urandom_range(0, 9) == 0, rnd(), $urandom_range(0, 299) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
